tx_serializer: RTL and testbench

//   Transmit-side counterpart of the RX CDR path: converts parallel symbols into a

---
 rtl/tx_serializer_if.sv | 10 +
 rtl/tx_serializer.sv | 118 +++++++++++
 tb/tb_tx_serializer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/tx_serializer_if.sv
// tx_serializer_if: valid/ready symbol handshake between the TX encoder and the serializer.
interface tx_serializer_if #(
   parameter int SYM_W = 10
);
   logic [SYM_W-1:0] TxData;
   logic             TxValid;
   logic             TxReady;
   modport master (output TxData, TxValid, input TxReady);
   modport slave  (input TxData, TxValid, output TxReady);
endinterface

// File: rtl/tx_serializer.sv
// tx_serializer: LSB-first symbol serializer with CDR training episodes, idle fill and a one-entry hold buffer.
module tx_serializer #(
   parameter int               SYM_W     = 10,
   parameter logic [SYM_W-1:0] IDLE_SYM  = SYM_W'(10'b0011111010),
   parameter logic [SYM_W-1:0] TRAIN_SYM = SYM_W'(10'b0101010101),
   parameter int               TRAIN_LEN = 64
) (
   input  logic          BitCLK,
   input  logic          Reset,
   input  logic          Enable,
   input  logic          TrainReq,
   tx_serializer_if.slave tx,
   output logic          TxSerial,
   output logic          SymStrobe,
   output logic          Training,
   output logic          Underrun,
   output logic [15:0]   SymCount
);
   localparam int BW = (SYM_W > 1) ? $clog2(SYM_W) : 1;
   localparam int TW = $clog2(TRAIN_LEN + 1);
   typedef enum logic [1:0] {OFF, TRAIN, RUN} state_t;
   state_t           state_q, state_d;
   logic [SYM_W-1:0] shreg_q, shreg_d, hold_q, hold_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [TW-1:0]    train_cnt_q, train_cnt_d;
   logic [15:0]      count_q, count_d;
   logic             hold_full_q, hold_full_d, pend_q, pend_d, strobe_q, strobe_d;
   logic             underrun_q, underrun_d, sent_q, sent_d;
   logic             boundary, ready, accept;
   // sent_q remembers data went out even if SymCount has wrapped back to zero
   always_comb begin
      boundary    = (bit_cnt_q == BW'(SYM_W - 1)) && (state_q != OFF);
      ready       = Enable && (state_q == RUN) && (!hold_full_q || (boundary && !pend_q));
      accept      = tx.TxValid && ready;
      state_d     = state_q;
      shreg_d     = shreg_q >> 1;
      bit_cnt_d   = bit_cnt_q + 1'b1;
      hold_d      = accept ? tx.TxData : hold_q;
      hold_full_d = hold_full_q || accept;
      train_cnt_d = train_cnt_q;
      pend_d      = pend_q || (TrainReq && (state_q == RUN));
      strobe_d    = boundary;
      underrun_d  = underrun_q;
      count_d     = count_q;
      sent_d      = sent_q;
      if (!Enable) begin
         state_d     = OFF;
         shreg_d     = '0;
         bit_cnt_d   = '0;
         hold_d      = '0;
         hold_full_d = 1'b0;
         train_cnt_d = '0;
         pend_d      = 1'b0;
         strobe_d    = 1'b0;
         underrun_d  = 1'b0;
         count_d     = '0;
         sent_d      = 1'b0;
      end else if (state_q == OFF) begin
         state_d     = TRAIN;
         shreg_d     = TRAIN_SYM;
         bit_cnt_d   = '0;
         train_cnt_d = '0;
         strobe_d    = 1'b1;
      end else if (boundary) begin
         bit_cnt_d = '0;
         if ((state_q == TRAIN) && (train_cnt_q != TW'(TRAIN_LEN - 1))) begin
            shreg_d     = TRAIN_SYM;
            train_cnt_d = train_cnt_q + 1'b1;
         end else if ((state_q == RUN) && pend_q) begin
            state_d     = TRAIN;
            shreg_d     = TRAIN_SYM;
            train_cnt_d = '0;
            pend_d      = 1'b0;
         end else begin
            // a held word always drains here, so the entry is full afterwards only if refilled now
            state_d     = RUN;
            shreg_d     = hold_full_q ? hold_q : IDLE_SYM;
            hold_full_d = accept;
            count_d     = hold_full_q ? count_q + 16'd1 : count_q;
            sent_d      = sent_q || hold_full_q;
            underrun_d  = underrun_q || (!hold_full_q && ((count_q != 16'd0) || sent_q));
         end
      end
   end
   always_ff @(posedge BitCLK or negedge Reset) begin
      if (!Reset) begin
         state_q     <= OFF;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         train_cnt_q <= '0;
         pend_q      <= 1'b0;
         strobe_q    <= 1'b0;
         underrun_q  <= 1'b0;
         count_q     <= '0;
         sent_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         train_cnt_q <= train_cnt_d;
         pend_q      <= pend_d;
         strobe_q    <= strobe_d;
         underrun_q  <= underrun_d;
         count_q     <= count_d;
         sent_q      <= sent_d;
      end
   end
   assign tx.TxReady = ready;
   assign TxSerial   = shreg_q[0];
   assign SymStrobe  = strobe_q;
   assign Training   = (state_q == TRAIN);
   assign Underrun   = underrun_q;
   assign SymCount   = count_q;
endmodule

// File: tb/tb_tx_serializer.sv
// tb_tx_serializer: directed stimulus with a symbol scoreboard fed on accept and drained by a bit-level monitor.
module tb_tx_serializer;
   localparam logic [9:0] IDLE = 10'b0011111010;
   localparam logic [9:0] TRN  = 10'b0101010101;
   logic BitCLK = 1'b0, Reset = 1'b0, Enable = 1'b0, TrainReq = 1'b0;
   logic TxSerial, SymStrobe, Training, Underrun;
   logic [15:0] SymCount;
   int tests = 0, fails = 0;
   logic [9:0] q[$];
   int bc = 0, since = 0, tr_run = 0, last_train = 0, train_done = 0, idle_cnt = 0;
   logic have_strobe = 1'b0, sym_tr = 1'b0, post_train = 1'b0, chk_boundary = 1'b0;
   logic [9:0] sym = '0, after_train = '0, exp_w = '0;
   tx_serializer_if #(.SYM_W(10)) tif();
   tx_serializer #(.TRAIN_LEN(4)) dut (
      .BitCLK(BitCLK), .Reset(Reset), .Enable(Enable), .TrainReq(TrainReq), .tx(tif.slave),
      .TxSerial(TxSerial), .SymStrobe(SymStrobe), .Training(Training), .Underrun(Underrun),
      .SymCount(SymCount)
   );
   always #5 BitCLK = ~BitCLK;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge BitCLK);
         #1;
      end
   endtask
   task automatic send(input logic [9:0] w);
      int n = 0;
      tif.TxData  = w;
      tif.TxValid = 1'b1;
      #1;
      while (!tif.TxReady && n < 100) begin
         tick();
         n++;
      end
      if (!tif.TxReady) check("send_ready", {31'd0, tif.TxReady}, 32'd1);
      else begin
         q.push_back(w);
         tick();
         if (chk_boundary && n > 0) check("accept_at_boundary", {31'd0, SymStrobe}, 32'd1);
      end
      tif.TxValid = 1'b0;
   endtask
   task automatic wait_train();
      int t0 = train_done;
      int n = 0;
      while (train_done == t0 && n < 300) begin
         tick();
         n++;
      end
      check("train_end", train_done, t0 + 1);
      check("train_len", last_train, 40);
   endtask
   task automatic wait_count(input int k);
      int n = 0;
      while (SymCount != 16'(k) && n < 60) begin
         tick();
         n++;
      end
      check("symcount", {16'd0, SymCount}, k);
   endtask
   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      check("drain", q.size(), 0);
   endtask
   // Monitor: rebuilds each symbol from the serial line and retires it against the scoreboard
   always @(negedge BitCLK) begin
      if (!Reset || !Enable) begin
         bc = 0;
         have_strobe = 1'b0;
         tr_run = 0;
         post_train = 1'b0;
      end else begin
         if (Training) tr_run++;
         else if (tr_run != 0) begin
            last_train = tr_run;
            tr_run = 0;
            train_done++;
         end
         if (SymStrobe) begin
            if (have_strobe) check("strobe_gap", since, 10);
            have_strobe = 1'b1;
            since = 1;
            sym = '0;
            sym[0] = TxSerial;
            bc = 1;
            sym_tr = Training;
         end else begin
            since++;
            if (bc != 0) begin
               sym[bc] = TxSerial;
               bc++;
            end
         end
         if (bc == 10) begin
            bc = 0;
            if (sym_tr) begin
               check("train_sym", {22'd0, sym}, {22'd0, TRN});
               post_train = 1'b1;
            end else begin
               if (post_train) begin
                  after_train = sym;
                  post_train = 1'b0;
               end
               if (sym == IDLE) idle_cnt++;
               else if (q.size() == 0) check("unexpected_data", {22'd0, sym}, {22'd0, IDLE});
               else begin
                  exp_w = q.pop_front();
                  check("data_sym", {22'd0, sym}, {22'd0, exp_w});
               end
            end
         end
      end
   end
   initial begin
      int i0;
      logic [9:0] w;
      tif.TxData  = '0;
      tif.TxValid = 1'b0;
      Enable = 1'b1;
      tick(2);
      check("rst_serial", {31'd0, TxSerial}, 0);
      check("rst_strobe", {31'd0, SymStrobe}, 0);
      check("rst_training", {31'd0, Training}, 0);
      check("rst_underrun", {31'd0, Underrun}, 0);
      check("rst_count", {16'd0, SymCount}, 0);
      check("rst_ready", {31'd0, tif.TxReady}, 0);
      Reset = 1'b1;
      wait_train();
      send(10'h2A5);
      send(10'h15A);
      wait_count(2);
      check("no_underrun", {31'd0, Underrun}, 0);
      i0 = idle_cnt;
      tick(25);
      check("underrun_set", {31'd0, Underrun}, 1);
      check("idle_inserted", {31'd0, idle_cnt > i0}, 1);
      chk_boundary = 1'b1;
      for (int i = 0; i < 100; i++) begin
         w = 10'($urandom_range(0, 1023));
         if (w == IDLE || w == TRN) w = w ^ 10'h001;
         send(w);
         tick($urandom_range(0, 12));
      end
      chk_boundary = 1'b0;
      drain();
      check("underrun_sticky", {31'd0, Underrun}, 1);
      send(10'h0F0);
      send(10'h30F);
      tick(3);
      TrainReq = 1'b1;
      tick();
      TrainReq = 1'b0;
      wait_train();
      tick(25);
      check("held_after_train", {22'd0, after_train}, 32'h30F);
      drain();
      check("underrun_kept", {31'd0, Underrun}, 1);
      send(10'h1C3);
      wait_count(int'(SymCount) + 1);
      tick(5);
      Enable = 1'b0;
      tick();
      check("dis_serial", {31'd0, TxSerial}, 0);
      check("dis_count", {16'd0, SymCount}, 0);
      check("dis_ready", {31'd0, tif.TxReady}, 0);
      check("dis_underrun", {31'd0, Underrun}, 0);
      check("dis_training", {31'd0, Training}, 0);
      q.delete();
      tick(2);
      Enable = 1'b1;
      wait_train();
      send(10'h2E1);
      wait_count(1);
      tick(25);
      check("underrun_pre_rst", {31'd0, Underrun}, 1);
      send(10'h0B4);
      wait_count(2);
      tick(5);
      Reset = 1'b0;
      tick();
      check("arst_serial", {31'd0, TxSerial}, 0);
      check("arst_count", {16'd0, SymCount}, 0);
      check("arst_ready", {31'd0, tif.TxReady}, 0);
      check("arst_underrun", {31'd0, Underrun}, 0);
      check("arst_strobe", {31'd0, SymStrobe}, 0);
      Reset = 1'b1;
      q.delete();
      tick(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
